// File: rtl/bus_cycle_controller.sv
// 68000-style bus cycle controller: per-region wait-state/external DTACK generation,
// interrupt acknowledge with autovector/claim, bus-error timeout, periodic timer and IPL encoding.
module bus_cycle_controller #(
  parameter int NUM_CS       = 4,
  parameter int WS_WIDTH     = 4,
  parameter int BERR_TIMEOUT = 64,
  parameter int TIMER_DIV    = 100000,
  parameter int TIMER_LEVEL  = 6
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         AS,
  input  logic                         IACK,
  input  logic [2:0]                   ADDR_L,
  input  logic [NUM_CS-1:0]            SEL,
  input  logic [NUM_CS-1:0]            EXT_MODE,
  input  logic [NUM_CS*WS_WIDTH-1:0]   WAIT_STATES,
  input  logic [NUM_CS-1:0]            EXT_DTACK,
  input  logic [6:0]                   IRQ_IN,
  input  logic [6:0]                   AUTOVEC,
  input  logic                         IACK_CLAIM,
  input  logic                         TIMER_EN,
  output logic                         DTACK,
  output logic                         BERR,
  output logic                         VPA,
  output logic [2:0]                   IPL,
  output logic                         TIMER_PEND
);

  localparam int RW  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TOW = $clog2(BERR_TIMEOUT + 1);
  localparam int TMW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [TOW-1:0] TO_LIMIT  = TOW'(BERR_TIMEOUT);
  localparam logic [TMW-1:0] TM_LIMIT  = TMW'(TIMER_DIV - 1);
  localparam logic [2:0]     TIMER_LVL = 3'(TIMER_LEVEL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    INT_WAIT = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [WS_WIDTH-1:0]   wait_cnt_r, wait_cnt_s;
  logic [TOW-1:0]        to_cnt_r, to_cnt_s, to_inc_s;
  logic [RW-1:0]         region_r, region_s;
  logic                  region_ok_r, region_ok_s;
  logic                  ext_r, ext_s;
  logic [2:0]            level_r, level_s;
  logic                  dtack_r, dtack_s;
  logic                  berr_r, berr_s;
  logic                  vpa_r, vpa_s;
  logic [2:0]            ipl_r;
  logic [TMW-1:0]        timer_cnt_r, timer_cnt_s;
  logic                  timer_pend_r, timer_pend_s;
  logic                  timer_wrap_s;
  logic                  timer_ack_s;

  logic [RW-1:0]         sel_idx_s;
  logic                  sel_any_s;
  logic [WS_WIDTH-1:0]   sel_ws_s;
  logic                  sel_ext_s;
  logic [7:0]            autovec_ext_s;
  logic [2:0]            irq_lvl_s;

  assign autovec_ext_s = {AUTOVEC, 1'b0};

  // Lowest-index active region decode; descending scan lets the lowest set bit win
  always_comb begin
    sel_idx_s = '0;
    sel_any_s = 1'b0;
    sel_ws_s  = '0;
    sel_ext_s = 1'b0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (SEL[i]) begin
        sel_idx_s = RW'(i);
        sel_any_s = 1'b1;
        sel_ws_s  = WAIT_STATES[i*WS_WIDTH +: WS_WIDTH];
        sel_ext_s = EXT_MODE[i];
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // Bus cycle FSM: next state, counters and strobe values
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    to_cnt_s    = to_cnt_r;
    region_s    = region_r;
    region_ok_s = region_ok_r;
    ext_s       = ext_r;
    level_s     = level_r;
    dtack_s     = dtack_r;
    berr_s      = berr_r;
    vpa_s       = vpa_r;
    timer_ack_s = 1'b0;
    to_inc_s    = (to_cnt_r == TO_LIMIT) ? to_cnt_r : to_cnt_r + TOW'(1);

    case (state_r)
      IDLE: begin
        dtack_s = 1'b1;
        berr_s  = 1'b1;
        vpa_s   = 1'b1;
        if (!AS) begin
          to_cnt_s    = '0;
          wait_cnt_s  = sel_ws_s;
          region_s    = sel_idx_s;
          region_ok_s = sel_any_s;
          ext_s       = sel_ext_s;
          level_s     = ADDR_L;
          state_s     = IACK ? MEM_WAIT : INT_WAIT;
        end else begin
          state_s = IDLE;
        end
      end

      MEM_WAIT: begin
        if (AS) begin
          state_s = IDLE;
        end else if (region_ok_r && !ext_r && (wait_cnt_r == '0)) begin
          dtack_s = 1'b0;
          state_s = HOLD;
        end else if (region_ok_r && ext_r && !EXT_DTACK[region_r]) begin
          dtack_s = 1'b0;
          state_s = HOLD;
        end else if (to_inc_s == TO_LIMIT) begin
          to_cnt_s = to_inc_s;
          berr_s   = 1'b0;
          state_s  = HOLD;
        end else begin
          to_cnt_s = to_inc_s;
          if (wait_cnt_r != '0) begin
            wait_cnt_s = wait_cnt_r - WS_WIDTH'(1);
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
        end
      end

      INT_WAIT: begin
        if (AS) begin
          state_s = IDLE;
        end else if ((level_r == TIMER_LVL) && timer_pend_r) begin
          vpa_s       = 1'b0;
          timer_ack_s = 1'b1;
          state_s     = HOLD;
        end else if (autovec_ext_s[level_r]) begin
          vpa_s   = 1'b0;
          state_s = HOLD;
        end else if (!IACK_CLAIM) begin
          dtack_s = 1'b0;
          state_s = HOLD;
        end else if (to_inc_s == TO_LIMIT) begin
          to_cnt_s = to_inc_s;
          berr_s   = 1'b0;
          state_s  = HOLD;
        end else begin
          to_cnt_s = to_inc_s;
        end
      end

      HOLD: begin
        if (AS) begin
          dtack_s = 1'b1;
          berr_s  = 1'b1;
          vpa_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        dtack_s = 1'b1;
        berr_s  = 1'b1;
        vpa_s   = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Periodic timer; a wrap on the same edge as an acknowledge keeps the request pending
  always_comb begin
    timer_wrap_s = TIMER_EN && (timer_cnt_r == TM_LIMIT);
    if (!TIMER_EN) begin
      timer_cnt_s = '0;
    end else if (timer_wrap_s) begin
      timer_cnt_s = '0;
    end else begin
      timer_cnt_s = timer_cnt_r + TMW'(1);
    end
    if (timer_wrap_s) begin
      timer_pend_s = 1'b1;
    end else if (timer_ack_s) begin
      timer_pend_s = 1'b0;
    end else begin
      timer_pend_s = timer_pend_r;
    end
  end

  // Highest pending interrupt level; ascending scan lets the highest level win
  always_comb begin
    irq_lvl_s = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (!IRQ_IN[i] || (timer_pend_r && (TIMER_LEVEL == i + 1))) begin
        irq_lvl_s = 3'(i + 1);
      end else begin
        irq_lvl_s = irq_lvl_s;
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= IDLE;
      wait_cnt_r   <= '0;
      to_cnt_r     <= '0;
      region_r     <= '0;
      region_ok_r  <= 1'b0;
      ext_r        <= 1'b0;
      level_r      <= 3'd0;
      dtack_r      <= 1'b1;
      berr_r       <= 1'b1;
      vpa_r        <= 1'b1;
      ipl_r        <= 3'b111;
      timer_cnt_r  <= '0;
      timer_pend_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_cnt_r   <= wait_cnt_s;
      to_cnt_r     <= to_cnt_s;
      region_r     <= region_s;
      region_ok_r  <= region_ok_s;
      ext_r        <= ext_s;
      level_r      <= level_s;
      dtack_r      <= dtack_s;
      berr_r       <= berr_s;
      vpa_r        <= vpa_s;
      ipl_r        <= ~irq_lvl_s;
      timer_cnt_r  <= timer_cnt_s;
      timer_pend_r <= timer_pend_s;
    end
  end

  assign DTACK      = dtack_r;
  assign BERR       = berr_r;
  assign VPA        = vpa_r;
  assign IPL        = ipl_r;
  assign TIMER_PEND = timer_pend_r;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench for bus_cycle_controller: expected strobe/latency per bus cycle is queued
// when the cycle is driven and compared when the controller answers.
module tb_bus_cycle_controller;

  localparam int NUM_CS = 4;
  localparam int WS_WIDTH = 4;
  localparam int MAX_WAIT = 200;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AS = 1'b1;
  logic        IACK = 1'b1;
  logic [2:0]  ADDR_L = 3'd0;
  logic [3:0]  SEL = 4'b0000;
  logic [3:0]  EXT_MODE = 4'b0000;
  logic [15:0] WAIT_STATES = 16'h0000;
  logic [3:0]  EXT_DTACK = 4'b1111;
  logic [6:0]  IRQ_IN = 7'b1111111;
  logic [6:0]  AUTOVEC = 7'b0000000;
  logic        IACK_CLAIM = 1'b1;
  logic        TIMER_EN = 1'b0;
  logic        DTACK, BERR, VPA, TIMER_PEND;
  logic [2:0]  IPL;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [2:0] strobes;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  bus_cycle_controller #(
    .NUM_CS(NUM_CS), .WS_WIDTH(WS_WIDTH), .BERR_TIMEOUT(64), .TIMER_DIV(10), .TIMER_LEVEL(6)
  ) dut (
    .CLK(CLK), .RST(RST), .AS(AS), .IACK(IACK), .ADDR_L(ADDR_L), .SEL(SEL),
    .EXT_MODE(EXT_MODE), .WAIT_STATES(WAIT_STATES), .EXT_DTACK(EXT_DTACK),
    .IRQ_IN(IRQ_IN), .AUTOVEC(AUTOVEC), .IACK_CLAIM(IACK_CLAIM), .TIMER_EN(TIMER_EN),
    .DTACK(DTACK), .BERR(BERR), .VPA(VPA), .IPL(IPL), .TIMER_PEND(TIMER_PEND)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one bus cycle starting on the next edge; strobes are {DTACK,BERR,VPA}
  task automatic run_cycle(input string tag, input logic iack, input logic [2:0] lvl,
                           input logic [2:0] exp_str, input int exp_lat, input int hold);
    exp_t e;
    int n;
    logic [2:0] obs;
    sb_q.push_back('{tag, exp_str, exp_lat});
    IACK = iack;
    ADDR_L = lvl;
    AS = 1'b0;
    n = -1;
    obs = 3'b111;
    while (obs == 3'b111 && n < MAX_WAIT) begin
      tick(1);
      n++;
      obs = {DTACK, BERR, VPA};
    end
    e = sb_q.pop_front();
    check_eq({e.tag, "_latency"}, n, e.lat);
    check_eq({e.tag, "_strobe"}, int'(obs), int'(e.strobes));
    if (hold > 0) begin
      tick(hold);
      check_eq({e.tag, "_held"}, int'({DTACK, BERR, VPA}), int'(e.strobes));
    end
    AS = 1'b1;
    tick(1);
    check_eq({e.tag, "_release"}, int'({DTACK, BERR, VPA}), 7);
    IACK = 1'b1;
  endtask

  initial begin
    int seen_low;
    tick(2);
    check_eq("rst_dtack", int'(DTACK), 1);
    check_eq("rst_berr", int'(BERR), 1);
    check_eq("rst_vpa", int'(VPA), 1);
    check_eq("rst_ipl", int'(IPL), 7);
    check_eq("rst_pend", int'(TIMER_PEND), 0);
    RST = 1'b1;
    tick(2);

    // internal wait states, lowest-index region selection, zero-wait boundary
    SEL = 4'b0010; WAIT_STATES[1*WS_WIDTH +: WS_WIDTH] = 4'd3;
    run_cycle("ws3", 1'b1, 3'd0, 3'b011, 4, 2);
    SEL = 4'b0001; WAIT_STATES = 16'h0000;
    run_cycle("ws0", 1'b1, 3'd0, 3'b011, 1, 1);
    SEL = 4'b0110; WAIT_STATES = 16'h0720;
    run_cycle("lowest", 1'b1, 3'd0, 3'b011, 3, 0);

    // external acknowledge and external timeout
    SEL = 4'b0100; EXT_MODE = 4'b0100; EXT_DTACK = 4'b1011;
    run_cycle("ext_ack", 1'b1, 3'd0, 3'b011, 1, 0);
    EXT_DTACK = 4'b1111;
    SEL = 4'b0001; EXT_MODE = 4'b0001;
    run_cycle("ext_to", 1'b1, 3'd0, 3'b101, 64, 2);
    EXT_MODE = 4'b0000;

    // unmapped access, AS held low for about 70 cycles
    SEL = 4'b0000;
    run_cycle("unmapped", 1'b1, 3'd0, 3'b101, 64, 6);

    // autovectored IACK
    AUTOVEC = 7'b0000100;
    run_cycle("autovec3", 1'b0, 3'd3, 3'b110, 1, 0);
    AUTOVEC = 7'b0000000;

    // IPL priority encoding
    IRQ_IN = 7'b1101101;
    tick(2);
    check_eq("ipl_2_5", int'(IPL), 2);
    IRQ_IN = 7'b0101101;
    tick(2);
    check_eq("ipl_7", int'(IPL), 0);
    IRQ_IN = 7'b1101101;
    tick(2);

    // device-claimed IACK, then unclaimed IACK timing out
    IACK_CLAIM = 1'b0;
    run_cycle("claim5", 1'b0, 3'd5, 3'b011, 1, 0);
    IACK_CLAIM = 1'b1;
    IRQ_IN = 7'b1111111;
    run_cycle("unclaimed", 1'b0, 3'd2, 3'b101, 64, 0);
    tick(1);
    check_eq("ipl_none", int'(IPL), 7);

    // periodic timer and its autovectored acknowledge
    TIMER_EN = 1'b1;
    tick(9);
    check_eq("timer_pend_9", int'(TIMER_PEND), 0);
    tick(1);
    check_eq("timer_pend_10", int'(TIMER_PEND), 1);
    tick(1);
    check_eq("timer_ipl", int'(IPL), 1);
    TIMER_EN = 1'b0;
    tick(3);
    check_eq("timer_pend_hold", int'(TIMER_PEND), 1);
    run_cycle("timer_ack", 1'b0, 3'd6, 3'b110, 1, 0);
    check_eq("timer_pend_clr", int'(TIMER_PEND), 0);
    tick(1);
    check_eq("timer_ipl_clr", int'(IPL), 7);

    // aborted cycle produces no strobe
    SEL = 4'b0001; WAIT_STATES = 16'h0005;
    AS = 1'b0;
    tick(3);
    AS = 1'b1;
    seen_low = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if ({DTACK, BERR, VPA} != 3'b111) seen_low = 1;
    end
    check_eq("abort_nostrobe", seen_low, 0);
    WAIT_STATES = 16'h0000;
    run_cycle("after_abort", 1'b1, 3'd0, 3'b011, 1, 0);

    // reset while a strobe is driven, AS still low at release
    AS = 1'b0;
    tick(2);
    check_eq("pre_rst_dtack", int'(DTACK), 0);
    RST = 1'b0;
    #1;
    check_eq("midrst_dtack", int'(DTACK), 1);
    check_eq("midrst_berr", int'(BERR), 1);
    check_eq("midrst_vpa", int'(VPA), 1);
    tick(1);
    RST = 1'b1;
    run_cycle("post_rst", 1'b1, 3'd0, 3'b011, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle_controller.md
BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 The block SHALL be parametrised as follows; all active-low signals are noted "(L)".
- NUM_CS, default 4: number of chip-select regions.
- WS_WIDTH, default 4: width of each wait-state count.
- BERR_TIMEOUT, default 64: CLK cycles before a bus error.
- TIMER_DIV, default 100000: periodic timer period in CLK cycles.
- TIMER_LEVEL, default 6: interrupt level of the timer.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  asynchronous active-low reset.
- AS  in  1  CPU address strobe (L).
- IACK  in  1  CPU-space/interrupt-acknowledge cycle (L).
- ADDR_L  in  3  acknowledged interrupt level during IACK.
- SEL  in  NUM_CS  region selects from the address decoder, active high.
- EXT_MODE  in  NUM_CS  per region: 1 = external DTACK, 0 = internal wait count.
- WAIT_STATES  in  NUM_CS*WS_WIDTH  per-region wait count; region i occupies bits [i*WS_WIDTH +: WS_WIDTH].
- EXT_DTACK  in  NUM_CS  per-region device acknowledge (L).
- IRQ_IN  in  7  level 1..7 requests (L); bit 0 = level 1.
- AUTOVEC  in  7  per-level autovector enable; bit 0 = level 1.
- IACK_CLAIM  in  1  device supplied a vector (L).
- TIMER_EN  in  1  periodic timer enable.
- DTACK  out  1  data acknowledge (L).
- BERR  out  1  bus error (L).
- VPA  out  1  autovector request (L).
- IPL  out  3  encoded interrupt level (L).
- TIMER_PEND  out  1  timer interrupt pending.

Function
REQ-003 All outputs SHALL be registered, with no combinational path from input to output.

REQ-004 The FSM SHALL have states IDLE, MEM_WAIT, INT_WAIT, HOLD; AS is sampled on each rising CLK.

REQ-005 IDLE SHALL transition as follows, loading the wait counter and clearing the timeout counter on entry:
- AS=0 and IACK=1 -> MEM_WAIT.
- AS=0 and IACK=0 -> INT_WAIT.

REQ-006 In MEM_WAIT, the active region SHALL be the lowest-index set bit of SEL, latched at cycle start.

REQ-007 An internal-mode region SHALL count WAIT_STATES[i] cycles, then assert DTACK=0 and enter HOLD. WAIT_STATES=0 gives DTACK on the first edge after cycle start; WAIT_STATES=N gives it N edges later.

REQ-008 An external-mode region SHALL assert DTACK=0 and enter HOLD on the edge after EXT_DTACK[i] is sampled 0.

REQ-009 In INT_WAIT, with L = ADDR_L sampled at cycle start, the priority SHALL be:
1. L==TIMER_LEVEL and TIMER_PEND=1 -> VPA=0 next edge; TIMER_PEND clears.
2. AUTOVEC[L-1]=1 -> VPA=0 next edge.
3. Otherwise, IACK_CLAIM sampled 0 -> DTACK=0.
Any of these SHALL enter HOLD.

REQ-010 In MEM_WAIT or INT_WAIT, the timeout counter SHALL increment each cycle. Reaching BERR_TIMEOUT SHALL assert BERR=0 and enter HOLD. This applies to no SEL bit set, a missing external DTACK, and an unclaimed IACK.

REQ-011 The block SHALL never assert DTACK, BERR and VPA in the same cycle; at most one is 0.

REQ-012 In HOLD, the asserted strobe SHALL be held until AS is sampled 1, then released on that edge with a transition to IDLE.

REQ-013 If AS is sampled 1 in MEM_WAIT or INT_WAIT (aborted cycle), the FSM SHALL return to IDLE with no strobe asserted.

REQ-014 IPL SHALL be the bitwise inverse of the highest active level among IRQ_IN and the timer (TIMER_PEND at TIMER_LEVEL), registered one cycle. With no request, IPL=3'b111.

REQ-015 With TIMER_EN=1, the timer counter SHALL count 0..TIMER_DIV-1. On wrap it returns to 0 and sets TIMER_PEND=1.

REQ-016 With TIMER_EN=0, the timer counter SHALL hold at 0 and TIMER_PEND SHALL hold its value.

REQ-017 If a timer wrap and a timer-acknowledge clear occur on the same edge, TIMER_PEND SHALL remain 1.

REQ-018 Counters SHALL saturate, never wrap. Each counter SHALL be the minimum width to hold its limit.

Reset
REQ-019 RST=0 SHALL immediately, without a clock, set state=IDLE, DTACK=1, BERR=1, VPA=1, IPL=3'b111, TIMER_PEND=0, and all counters to 0.

REQ-020 Reset asserted mid-cycle SHALL abort the cycle, leaving no strobe asserted.

REQ-021 After RST rises, the first cycle start SHALL be recognised on the first edge with AS=0.

Verification
REQ-022 Internal wait: SEL=4'b0010, EXT_MODE=0, WAIT_STATES[1]=3, AS falls -> DTACK=0 on the 4th edge after AS is sampled 0; DTACK=1 on the edge AS is sampled 1.

REQ-023 External plus timeout: SEL=4'b0001, EXT_MODE=1, EXT_DTACK held 1 -> BERR=0 after 64 cycles; DTACK stays 1.

REQ-024 Unmapped: SEL=0, AS=0 for 70 cycles -> BERR=0 at cycle 64; release on AS high; FSM returns to IDLE.

REQ-025 Timer autovector: TIMER_DIV=10, TIMER_EN=1 -> TIMER_PEND=1 after 10 cycles, IPL=3'b001. IACK cycle with ADDR_L=6 -> VPA=0, TIMER_PEND=0.

REQ-026 Priority and claim: IRQ_IN levels 2 and 5 low -> IPL=3'b010. IACK with ADDR_L=5, AUTOVEC=0, IACK_CLAIM=0 -> DTACK=0, VPA=1.

REQ-027 Reset mid-cycle: RST=0 during MEM_WAIT -> all strobes 1 immediately. After RST rises, a new AS=0 starts a fresh cycle.
